// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line and frame config in, byte and status strobes out.
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
);
   logic                  RX_IN;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [PRESCALE_W-1:0] PRESCALE;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_ERR;
   logic                  STP_ERR;

   modport master (
      output RX_IN, PAR_EN, PAR_TYP, PRESCALE,
      input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
   );

   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP, PRESCALE,
      output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, 3-sample majority vote, LSB-first deserialize, parity/stop check.
// DATA_VALID lands (DATA_WIDTH+2)*P cycles after the start edge (+P with parity); no backpressure, strobes are fire-and-forget.
module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic     CLK,
   input  logic     RST,
   uart_rx_if.slave bus
);

   localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [4:0] S_IDLE   = 5'b00001;
   localparam logic [4:0] S_START  = 5'b00010;
   localparam logic [4:0] S_DATA   = 5'b00100;
   localparam logic [4:0] S_PARITY = 5'b01000;
   localparam logic [4:0] S_STOP   = 5'b10000;

   logic [4:0]            state;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [PRESCALE_W-1:0] presc_q;
   logic [BC_W-1:0]       bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] p_data;
   logic [2:0]            samp;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  frame_bad;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;

   logic [PRESCALE_W-1:0] half;
   logic                  last_edge;
   logic                  voted;
   logic                  exp_par;

   always_comb begin
      half      = presc_q >> 1;
      last_edge = (edge_cnt == presc_q - PRESCALE_W'(1));
      voted     = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
      exp_par   = (^shreg) ^ par_typ_q;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= S_IDLE;
         edge_cnt   <= '0;
         presc_q    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         p_data     <= '0;
         samp       <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         frame_bad  <= 1'b0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;

         // Three samples straddle the bit centre; the vote is settled well before edge P-1.
         if (state != S_IDLE) begin
            if (edge_cnt == half - PRESCALE_W'(1)) samp[0] <= bus.RX_IN;
            if (edge_cnt == half)                  samp[1] <= bus.RX_IN;
            if (edge_cnt == half + PRESCALE_W'(1)) samp[2] <= bus.RX_IN;
            edge_cnt <= last_edge ? '0 : edge_cnt + PRESCALE_W'(1);
         end

         case (state)
            S_IDLE: begin
               if (!bus.RX_IN) begin
                  state     <= S_START;
                  edge_cnt  <= PRESCALE_W'(1);
                  presc_q   <= bus.PRESCALE;
                  par_en_q  <= bus.PAR_EN;
                  par_typ_q <= bus.PAR_TYP;
                  frame_bad <= 1'b0;
                  bit_cnt   <= '0;
               end
            end
            S_START: begin
               if (last_edge) state <= voted ? S_IDLE : S_DATA;
            end
            S_DATA: begin
               if (last_edge) begin
                  shreg <= {voted, shreg[DATA_WIDTH-1:1]};
                  if (bit_cnt == BC_W'(DATA_WIDTH - 1)) begin
                     bit_cnt <= '0;
                     state   <= par_en_q ? S_PARITY : S_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + BC_W'(1);
                  end
               end
            end
            S_PARITY: begin
               if (last_edge) begin
                  if (voted != exp_par) begin
                     par_err   <= 1'b1;
                     frame_bad <= 1'b1;
                  end
                  state <= S_STOP;
               end
            end
            S_STOP: begin
               if (last_edge) begin
                  if (!voted) begin
                     stp_err <= 1'b1;
                  end else if (!frame_bad) begin
                     p_data     <= shreg;
                     data_valid <= 1'b1;
                  end
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.P_DATA     = p_data;
   assign bus.DATA_VALID = data_valid;
   assign bus.PAR_ERR    = par_err;
   assign bus.STP_ERR    = stp_err;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the UART link; mirror of the transmit path.
- Oversamples the serial line RX_IN at PRESCALE clocks per bit and detects the start bit.
- Majority-votes each bit, deserializes LSB-first data, then checks optional parity and the stop bit.
- Presents a parallel byte with a one-cycle DATA_VALID strobe. Sits between the pad synchronizer and the system-side RX consumer (register file / FIFO).

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of PRESCALE input

Ports:
CLK  input  1  oversampling clock
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, already synchronized to CLK, idle high
PAR_EN  input  1  1 = frame carries parity bit
PAR_TYP  input  1  0 = even, 1 = odd parity
PRESCALE  input  PRESCALE_W  clocks per bit; legal values 8, 16, 32
P_DATA  output  DATA_WIDTH  last good received byte
DATA_VALID  output  1  one-cycle strobe, P_DATA updated this cycle
PAR_ERR  output  1  one-cycle strobe, parity mismatch
STP_ERR  output  1  one-cycle strobe, stop bit sampled 0

Behaviour:
- Reset (RST=0, async): FSM to IDLE; P_DATA=0; DATA_VALID=PAR_ERR=STP_ERR=0; all counters and shift register cleared. Reset mid-frame abandons the frame; no strobes are issued.
- Register all outputs. Strobes last exactly one CLK.
- Counters:
  - edge_cnt runs 0..PRESCALE-1 within each bit.
  - bit_cnt runs 0..DATA_WIDTH-1 in DATA.
  - Wrap edge_cnt to 0 at PRESCALE-1 and advance to the next bit or state.
- Start detection:
  - The first IDLE cycle with RX_IN=0 is edge 0 of the start bit (cycle 0).
  - Latch PAR_EN, PAR_TYP and PRESCALE in that cycle. Changes mid-frame are ignored.
  - Go to START with edge_cnt=1.
- Sampling: take RX_IN at edges P/2-1, P/2, P/2+1 (P = latched PRESCALE). The bit value is the majority of the 3 samples and is valid from edge P/2+2.
- FSM (one-hot, 5 states):
  - IDLE: RX_IN=0 -> START; else stay.
  - START: at edge P-1, voted bit 0 -> DATA; voted bit 1 -> IDLE (glitch rejected, no strobes).
  - DATA: at edge P-1, shift the voted bit into the register, LSB first. After bit DATA_WIDTH-1: -> PARITY if PAR_EN, else -> STOP.
  - PARITY:
    - At edge P-1, compute the expected bit: XOR of the data bits for even, its inverse for odd.
    - Mismatch -> PAR_ERR=1 next cycle and mark the frame bad.
    - Always -> STOP.
  - STOP: at edge P-1, voted 0 -> STP_ERR=1 next cycle. If the frame is good and the stop bit is 1 -> P_DATA=shift register and DATA_VALID=1 next cycle. Always -> IDLE.
- Latency, with start edge = cycle 0:
  - No parity: DATA_VALID high in cycle (DATA_WIDTH+2)*P.
  - With parity: DATA_VALID high in cycle (DATA_WIDTH+3)*P.
- Back-to-back frames: IDLE is re-entered in the strobe cycle. A low RX_IN in that cycle is the next start edge (cycle 0), so there is zero idle gap after the stop bit.
- Bad frames: P_DATA keeps its previous value. PAR_ERR and STP_ERR may both fire for the same frame, each in its own cycle.
- Illegal PRESCALE values (anything other than 8/16/32): behaviour is undefined and is not verified.

Test Plan:
- P=8, no parity, frame 0xA5 with start at cycle 0 -> DATA_VALID=1 only in cycle 80, P_DATA=0xA5, no error strobes.
- P=16, PAR_EN=1, PAR_TYP=0, byte 0x3C, parity bit 0 -> DATA_VALID in cycle 176, P_DATA=0x3C. Same frame with parity bit 1 -> PAR_ERR pulse in cycle 160+16=176? No: PAR_ERR asserts in cycle 9*16+16=160, then no DATA_VALID.
- P=8, byte 0x81, stop bit driven 0 -> STP_ERR pulse in cycle 80, DATA_VALID stays 0, P_DATA unchanged.
- P=8, RX_IN low for 2 cycles then high (glitch) -> FSM returns to IDLE at cycle 8, no strobes; a valid 0x55 frame that follows is received correctly.
- P=32, two back-to-back frames 0x0F then 0xF0 with no idle gap -> DATA_VALID in cycles 320 and 640 with the correct P_DATA each time. A single-sample spike on the centre edge of a data bit is outvoted.
- Assert RST mid-DATA of a 0xC3 frame -> all outputs 0 immediately; no strobe for the partial frame; the next 0x12 frame is received correctly.
